// File: rtl/byte_decoder.sv
// Descrambling byte decoder with a 2-entry output buffer.
// A stalled consumer is flushed after TIMEOUT cycles.
module byte_decoder #(
   parameter logic [9:0]  KEY     = 10'h00a,
   parameter int unsigned SHIFT   = 2,
   parameter logic [31:0] TIMEOUT = 32'h17d7840
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        timeout,
   output logic [15:0] byte_count
);

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ONE,
      S_FULL
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [7:0]  r_d0;
   logic [7:0]  r_d1;
   logic [7:0]  w_d0_nxt;
   logic [7:0]  w_d1_nxt;
   logic        r_live;
   logic [31:0] r_stall_cnt;
   logic [31:0] w_stall_nxt;
   logic [15:0] r_count;

   logic [7:0]  w_dec;
   logic        w_stall;
   logic        w_timeout;
   logic        w_ready;
   logic        w_push;
   logic        w_pop;

   // Key is aligned by SHIFT before mixing, evaluated at 10 bits.
   assign w_dec =
      8'((({2'b00, in_data} << SHIFT) ^ KEY) >> SHIFT);

   assign out_valid  = (r_state != S_EMPTY);
   assign out_data   = r_d0;
   assign byte_count = r_count;

   assign w_stall   = out_valid && !out_ready;
   assign w_timeout = w_stall &&
                      (r_stall_cnt == TIMEOUT - 32'd1);
   assign w_ready   = r_live && (r_state != S_FULL) &&
                      !w_timeout;
   assign w_push    = in_valid && w_ready;
   assign w_pop     = out_valid && out_ready;

   assign in_ready = w_ready;
   assign timeout  = w_timeout;

   always_comb begin
      w_state_nxt = r_state;
      w_d0_nxt    = r_d0;
      w_d1_nxt    = r_d1;
      if (w_timeout) begin
         w_state_nxt = S_EMPTY;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_push) begin
                  w_state_nxt = S_ONE;
                  w_d0_nxt    = w_dec;
               end
            end
            S_ONE: begin
               unique case ({w_push, w_pop})
                  2'b10: begin
                     w_state_nxt = S_FULL;
                     w_d1_nxt    = w_dec;
                  end
                  2'b01: w_state_nxt = S_EMPTY;
                  2'b11: w_d0_nxt = w_dec;
                  default: ;
               endcase
            end
            S_FULL: begin
               if (w_pop) begin
                  w_state_nxt = S_ONE;
                  w_d0_nxt    = r_d1;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Counter saturates rather than wrapping.
   always_comb begin
      w_stall_nxt = 32'd0;
      if (w_stall && !w_timeout) begin
         if (r_stall_cnt != 32'hffff_ffff)
            w_stall_nxt = r_stall_cnt + 32'd1;
         else
            w_stall_nxt = r_stall_cnt;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_EMPTY;
         r_d0        <= 8'h00;
         r_d1        <= 8'h00;
         r_live      <= 1'b0;
         r_stall_cnt <= 32'd0;
         r_count     <= 16'h0000;
      end else begin
         r_state     <= w_state_nxt;
         r_d0        <= w_d0_nxt;
         r_d1        <= w_d1_nxt;
         r_live      <= 1'b1;
         r_stall_cnt <= w_stall_nxt;
         if (w_pop)
            r_count <= r_count + 16'd1;
      end
   end

endmodule
